// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared types and constants for the GPU DMA reader
// Purpose: state encoding of the DMA reader FSM, fixed AXI field values and the
//          4 KB page size that bursts must not straddle.
// Ports:   none (package).
package painterengine_gpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DATA  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5,
      ST_DRAIN = 3'd6
   } dmareader_state_t;

   localparam logic [2:0]  ARSIZE_4B    = 3'b010;
   localparam logic [1:0]  ARBURST_INCR = 2'b01;
   localparam logic [1:0]  RRESP_OKAY   = 2'b00;
   localparam logic [12:0] BOUNDARY_4KB = 13'h1000;

endpackage

// File: rtl/painterengine_gpu_dmareader_burstcalc.sv
// rtl/painterengine_gpu_dmareader_burstcalc.sv - beat count for the next AXI burst
// Purpose: combinational min(remaining, PARAM_MAX_BURST, words left in the 4 KB page).
// Ports:   i_wire_remaining   words still to fetch (never 0 when used)
//          i_wire_addr_offset byte offset of the burst start inside its 4 KB page
//          o_wire_beats       beats for this burst, 1..PARAM_MAX_BURST
module painterengine_gpu_dmareader_burstcalc
   import painterengine_gpu_pkg::*;
#(
   parameter int PARAM_MAX_BURST = 16
) (
   input  logic [31:0] i_wire_remaining,
   input  logic [11:0] i_wire_addr_offset,
   output logic [8:0]  o_wire_beats
);

   logic [12:0] bytes_to_boundary;
   logic [10:0] boundary_beats;

   always_comb begin
      bytes_to_boundary = BOUNDARY_4KB - {1'b0, i_wire_addr_offset};
      // offset is word aligned, so the low two bits are always zero
      boundary_beats    = bytes_to_boundary[12:2];
      o_wire_beats      = 9'(PARAM_MAX_BURST);
      if ({21'd0, boundary_beats} < {23'd0, o_wire_beats}) begin
         o_wire_beats = boundary_beats[8:0];
      end
      if (i_wire_remaining < {23'd0, o_wire_beats}) begin
         o_wire_beats = i_wire_remaining[8:0];
      end
   end

endmodule

// File: rtl/painterengine_gpu_dmareader.sv
// rtl/painterengine_gpu_dmareader.sv - AXI4 read master feeding the display pixel stream
// Purpose: fetches i_wire_length 32-bit words from i_wire_address as INCR bursts
//          (<= PARAM_MAX_BURST beats, never across 4 KB) and forwards them on a
//          data/valid/next stream. Optional cycle counter under
//          PAINTERENGINE_GPU_DMAREADER_PERF_EN (adds o_wire_perf_cycles).
// Ports:   i_wire_clock/i_wire_resetn  clock, async active-low reset
//          i_wire_enable/address/length  request control; o_wire_done/error status
//          o_wire_data/data_valid, i_wire_data_next  pixel stream
//          o_wire_ar*/i_wire_arready, i_wire_r*/o_wire_rready  AXI read channels
module painterengine_gpu_dmareader
   import painterengine_gpu_pkg::*;
#(
   parameter int PARAM_MAX_BURST  = 16,
   parameter int PARAM_ADDR_WIDTH = 32
) (
   input  logic                        i_wire_clock,
   input  logic                        i_wire_resetn,
   input  logic                        i_wire_enable,
   input  logic [31:0]                 i_wire_address,
   input  logic [31:0]                 i_wire_length,
   output logic                        o_wire_done,
   output logic                        o_wire_error,
   output logic [31:0]                 o_wire_data,
   output logic                        o_wire_data_valid,
   input  logic                        i_wire_data_next,
   output logic [PARAM_ADDR_WIDTH-1:0] o_wire_araddr,
   output logic [7:0]                  o_wire_arlen,
   output logic [2:0]                  o_wire_arsize,
   output logic [1:0]                  o_wire_arburst,
   output logic                        o_wire_arvalid,
   input  logic                        i_wire_arready,
   input  logic [31:0]                 i_wire_rdata,
   input  logic [1:0]                  i_wire_rresp,
   input  logic                        i_wire_rlast,
   input  logic                        i_wire_rvalid,
   output logic                        o_wire_rready
`ifdef PAINTERENGINE_GPU_DMAREADER_PERF_EN
   ,
   output logic [31:0]                 o_wire_perf_cycles
`endif
);

   dmareader_state_t            state;
   logic [PARAM_ADDR_WIDTH-1:0] addr_q;
   logic [31:0]                 remaining_q;
   logic [31:0]                 remaining_next;
   logic                        burst_err_q;
   logic [PARAM_ADDR_WIDTH-1:0] araddr_q;
   logic [7:0]                  arlen_q;
   logic                        arvalid_q;
   logic                        done_q;
   logic                        error_q;
   logic [8:0]                  calc_beats;
   logic                        in_data;
   logic                        in_drain;
   logic                        rready;
   logic                        beat;
   logic                        beat_err;

   painterengine_gpu_dmareader_burstcalc #(
      .PARAM_MAX_BURST (PARAM_MAX_BURST)
   ) u_burstcalc (
      .i_wire_remaining   (remaining_q),
      .i_wire_addr_offset (addr_q[11:0]),
      .o_wire_beats       (calc_beats)
   );

   // Stream path is combinational: the consumer's next drives rready directly.
   // After an error response the rest of the burst is swallowed regardless of next.
   assign in_data        = (state == ST_DATA);
   assign in_drain       = (state == ST_DRAIN);
   assign rready         = in_drain | (in_data & (i_wire_data_next | burst_err_q));
   assign beat           = i_wire_rvalid & rready;
   assign beat_err       = (i_wire_rresp != RRESP_OKAY);
   assign remaining_next = (remaining_q != 32'd0) ? remaining_q - 32'd1 : 32'd0;

   assign o_wire_rready     = rready;
   assign o_wire_data       = in_data ? i_wire_rdata : 32'd0;
   assign o_wire_data_valid = in_data & beat & ~burst_err_q & ~beat_err;
   assign o_wire_araddr     = araddr_q;
   assign o_wire_arlen      = arlen_q;
   assign o_wire_arvalid    = arvalid_q;
   assign o_wire_arsize     = ARSIZE_4B;
   assign o_wire_arburst    = ARBURST_INCR;
   assign o_wire_done       = done_q;
   assign o_wire_error      = error_q;

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= 32'd0;
         burst_err_q <= 1'b0;
         araddr_q    <= '0;
         arlen_q     <= 8'd0;
         arvalid_q   <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q  <= 1'b0;
               error_q <= 1'b0;
               if (i_wire_enable) begin
                  addr_q      <= PARAM_ADDR_WIDTH'(i_wire_address);
                  remaining_q <= i_wire_length;
                  if (i_wire_length == 32'd0) begin
                     done_q <= 1'b1;
                     state  <= ST_DONE;
                  end else if (i_wire_address[1:0] != 2'b00) begin
                     error_q <= 1'b1;
                     state   <= ST_ERROR;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (!i_wire_enable) begin
                  state <= ST_IDLE;
               end else begin
                  araddr_q    <= addr_q;
                  arlen_q     <= 8'(calc_beats - 9'd1);
                  arvalid_q   <= 1'b1;
                  burst_err_q <= 1'b0;
                  state       <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               // arvalid may not be withdrawn once raised, even on abort;
               // an aborted burst is accepted and then discarded in DRAIN.
               if (i_wire_arready) begin
                  arvalid_q <= 1'b0;
                  state     <= i_wire_enable ? ST_DATA : ST_DRAIN;
               end
            end
            ST_DATA: begin
               if (beat) begin
                  remaining_q <= remaining_next;
                  addr_q      <= addr_q + PARAM_ADDR_WIDTH'(4);
                  if (beat_err) begin
                     burst_err_q <= 1'b1;
                  end
               end
               if (beat && i_wire_rlast) begin
                  if (!i_wire_enable) begin
                     state <= ST_IDLE;
                  end else if (burst_err_q || beat_err) begin
                     error_q <= 1'b1;
                     state   <= ST_ERROR;
                  end else if (remaining_next == 32'd0) begin
                     done_q <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end else if (!i_wire_enable) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (beat && i_wire_rlast) begin
                  state <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (!i_wire_enable) begin
                  done_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            ST_ERROR: begin
               if (!i_wire_enable) begin
                  error_q <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef PAINTERENGINE_GPU_DMAREADER_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         perf_q <= 32'd0;
      end else if (state == ST_IDLE) begin
         if (i_wire_enable) begin
            perf_q <= 32'd0;
         end
      end else if (state != ST_DONE && state != ST_ERROR && perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign o_wire_perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_painterengine_gpu_dmareader.sv
// tb/tb_painterengine_gpu_dmareader.sv - directed self-checking bench for the GPU DMA reader
module tb_painterengine_gpu_dmareader;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] length = 32'd0;
   logic        data_next = 1'b0;
   logic        arready = 1'b0;
   logic [31:0] rdata = 32'd0;
   logic [1:0]  rresp = 2'd0;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;

   logic        done, error, data_valid, arvalid, rready;
   logic [31:0] data, araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
`ifdef PAINTERENGINE_GPU_DMAREADER_PERF_EN
   logic [31:0] perf_cycles;
`endif

   always #5 clk = ~clk;

   painterengine_gpu_dmareader #(
      .PARAM_MAX_BURST  (16),
      .PARAM_ADDR_WIDTH (32)
   ) dut (
      .i_wire_clock      (clk),
      .i_wire_resetn     (resetn),
      .i_wire_enable     (enable),
      .i_wire_address    (address),
      .i_wire_length     (length),
      .o_wire_done       (done),
      .o_wire_error      (error),
      .o_wire_data       (data),
      .o_wire_data_valid (data_valid),
      .i_wire_data_next  (data_next),
      .o_wire_araddr     (araddr),
      .o_wire_arlen      (arlen),
      .o_wire_arsize     (arsize),
      .o_wire_arburst    (arburst),
      .o_wire_arvalid    (arvalid),
      .i_wire_arready    (arready),
      .i_wire_rdata      (rdata),
      .i_wire_rresp      (rresp),
      .i_wire_rlast      (rlast),
      .i_wire_rvalid     (rvalid),
      .o_wire_rready     (rready)
`ifdef PAINTERENGINE_GPU_DMAREADER_PERF_EN
      ,
      .o_wire_perf_cycles (perf_cycles)
`endif
   );

   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // memory slave / stream sink state
   logic [31:0] ar_addr_q[$];
   logic [7:0]  ar_len_q[$];
   logic [31:0] out_q[$];
   bit          burst_active = 0;
   logic [31:0] b_addr = 32'd0;
   int          b_len = 0, b_idx = 0, req_beat = 0, err_beat = -1;
   int          mode = 0, abort_after = 0, cyc = 0;
   bit          abort_pending = 0, aborted = 0;
   int          mirror_bad = 0, valid_after_abort = 0, flag_during_abort = 0;
   int          r_accepted = 0, cross_bad = 0, arfield_bad = 0;

   // Drive on the falling edge, then sample #1 later: nothing changes again
   // before the rising edge, so the sampled handshakes are the ones that occur.
   always @(negedge clk) begin
      cyc++;
      arready = resetn;
      if (burst_active) begin
         rvalid = 1'b1;
         rdata  = word_at(b_addr + 32'(4 * b_idx));
         rlast  = (b_idx == b_len);
         rresp  = (req_beat == err_beat) ? 2'b10 : 2'b00;
      end else begin
         rvalid = 1'b0;
         rdata  = 32'd0;
         rlast  = 1'b0;
         rresp  = 2'b00;
      end
      if (abort_pending && !aborted) begin
         aborted = 1;
         enable  = 1'b0;
      end
      case (mode)
         1:       data_next = cyc[0];
         2:       data_next = !aborted;
         default: data_next = 1'b1;
      endcase
      #1;
      if (mode == 1 && rvalid && (rready !== data_next)) mirror_bad++;
      if (aborted && data_valid) valid_after_abort++;
      if (aborted && (done || error)) flag_during_abort++;
      if (data_valid && data_next) out_q.push_back(data);
      if (rvalid && rready) begin
         r_accepted++;
         req_beat++;
         if (b_idx == b_len) burst_active = 0;
         else b_idx++;
      end
      if (arvalid && arready) begin
         ar_addr_q.push_back(araddr);
         ar_len_q.push_back(arlen);
         if ({20'd0, araddr[11:0]} + (32'(arlen) + 32'd1) * 4 > 32'd4096) cross_bad++;
         if (arsize != 3'b010 || arburst != 2'b01) arfield_bad++;
         burst_active = 1;
         b_addr = araddr;
         b_len  = int'(arlen);
         b_idx  = 0;
      end
      if (mode == 2 && !aborted && out_q.size() == abort_after) abort_pending = 1;
   end

   task automatic clear_logs();
      ar_addr_q.delete();
      ar_len_q.delete();
      out_q.delete();
      req_beat = 0; r_accepted = 0; mirror_bad = 0;
      valid_after_abort = 0; flag_during_abort = 0;
      abort_pending = 0; aborted = 0; err_beat = -1;
   endtask

   task automatic start_req(input logic [31:0] a, input logic [31:0] n);
      @(negedge clk);
      address = a;
      length  = n;
      enable  = 1'b1;
   endtask

   task automatic wait_end(input string tag);
      bit seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         #2;
         seen = done || error;
      end
      check_eq({tag, " finished"}, 32'(seen), 32'd1);
   endtask

   task automatic end_req(input string tag);
      @(negedge clk);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check_eq({tag, " done cleared"}, 32'(done), 32'd0);
      check_eq({tag, " error cleared"}, 32'(error), 32'd0);
   endtask

   task automatic check_words(input string tag, input logic [31:0] base, input int n);
      int wrong = 0;
      check_eq({tag, " word count"}, 32'(out_q.size()), 32'(n));
      for (int i = 0; i < out_q.size() && i < n; i++)
         if (out_q[i] !== word_at(base + 32'(4 * i))) wrong++;
      check_eq({tag, " word order"}, 32'(wrong), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #2;
      check_eq("reset done", 32'(done), 32'd0);
      check_eq("reset error", 32'(error), 32'd0);
      check_eq("reset arvalid", 32'(arvalid), 32'd0);
      check_eq("reset araddr", araddr, 32'd0);
      check_eq("reset arlen", 32'(arlen), 32'd0);
      check_eq("reset arsize", 32'(arsize), 32'd2);
      check_eq("reset arburst", 32'(arburst), 32'd1);
      check_eq("reset rready", 32'(rready), 32'd0);
      check_eq("reset data_valid", 32'(data_valid), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // four aligned 16-beat bursts
      clear_logs(); mode = 0;
      start_req(32'h0000_1000, 32'd64);
      wait_end("t1");
      check_eq("t1 done", 32'(done), 32'd1);
      check_eq("t1 error", 32'(error), 32'd0);
      check_eq("t1 ar count", 32'(ar_addr_q.size()), 32'd4);
      for (int i = 0; i < ar_addr_q.size() && i < 4; i++) begin
         check_eq($sformatf("t1 araddr%0d", i), ar_addr_q[i], 32'h1000 + 32'(i * 64));
         check_eq($sformatf("t1 arlen%0d", i), 32'(ar_len_q[i]), 32'd15);
      end
      check_words("t1", 32'h1000, 64);
      repeat (3) @(negedge clk);
      #2;
      check_eq("t1 done held", 32'(done), 32'd1);
      end_req("t1");

      // 4 KB boundary split
      clear_logs();
      start_req(32'h0000_1FF8, 32'd10);
      wait_end("t2");
      check_eq("t2 done", 32'(done), 32'd1);
      check_eq("t2 ar count", 32'(ar_addr_q.size()), 32'd2);
      if (ar_addr_q.size() == 2) begin
         check_eq("t2 araddr0", ar_addr_q[0], 32'h1FF8);
         check_eq("t2 arlen0", 32'(ar_len_q[0]), 32'd1);
         check_eq("t2 araddr1", ar_addr_q[1], 32'h2000);
         check_eq("t2 arlen1", 32'(ar_len_q[1]), 32'd7);
      end
      check_words("t2", 32'h1FF8, 10);
      end_req("t2");

      // consumer back-pressure toggling every cycle
      clear_logs(); mode = 1;
      start_req(32'h0000_3000, 32'd40);
      wait_end("t3");
      check_eq("t3 done", 32'(done), 32'd1);
      check_eq("t3 rready mirrors next", 32'(mirror_bad), 32'd0);
      check_eq("t3 ar count", 32'(ar_addr_q.size()), 32'd3);
      if (ar_len_q.size() == 3) check_eq("t3 last arlen", 32'(ar_len_q[2]), 32'd7);
      check_words("t3", 32'h3000, 40);
      mode = 0;
      end_req("t3");

      // error response on the fifth beat
      clear_logs(); err_beat = 4;
      start_req(32'h0000_4000, 32'd16);
      wait_end("t4");
      check_eq("t4 error", 32'(error), 32'd1);
      check_eq("t4 done", 32'(done), 32'd0);
      check_eq("t4 beats drained", 32'(r_accepted), 32'd16);
      check_words("t4", 32'h4000, 4);
      end_req("t4");

      // abort after three words of the first burst
      clear_logs(); mode = 2; abort_after = 3;
      start_req(32'h0000_5000, 32'd32);
      begin
         bit fin = 0;
         for (int i = 0; i < 500 && !fin; i++) begin
            @(negedge clk);
            #2;
            fin = aborted && (r_accepted == 16) && !burst_active;
         end
         check_eq("t5 drain finished", 32'(fin), 32'd1);
      end
      repeat (10) @(negedge clk);
      #2;
      check_eq("t5 ar count", 32'(ar_addr_q.size()), 32'd1);
      check_eq("t5 words before abort", 32'(out_q.size()), 32'd3);
      check_eq("t5 valid while draining", 32'(valid_after_abort), 32'd0);
      check_eq("t5 flags during abort", 32'(flag_during_abort), 32'd0);
      check_eq("t5 beats accepted", 32'(r_accepted), 32'd16);
      mode = 0;
      clear_logs();
      start_req(32'h0000_6000, 32'd8);
      wait_end("t5 restart");
      check_eq("t5 restart done", 32'(done), 32'd1);
      check_words("t5 restart", 32'h6000, 8);
      end_req("t5 restart");

      // zero length, then misaligned address
      clear_logs();
      start_req(32'h0000_1000, 32'd0);
      wait_end("t6a");
      check_eq("t6a done", 32'(done), 32'd1);
      check_eq("t6a error", 32'(error), 32'd0);
      check_eq("t6a ar count", 32'(ar_addr_q.size()), 32'd0);
      end_req("t6a");
      clear_logs();
      start_req(32'h0000_1002, 32'd5);
      wait_end("t6b");
      check_eq("t6b error", 32'(error), 32'd1);
      check_eq("t6b done", 32'(done), 32'd0);
      check_eq("t6b ar count", 32'(ar_addr_q.size()), 32'd0);
      end_req("t6b");

      check_eq("no 4KB crossing", 32'(cross_bad), 32'd0);
      check_eq("ar size/burst fields", 32'(arfield_bad), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
